// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: queues FPU commands, issues them one at a time and
// returns results with sticky fflags. Optional macro FPU_SEQ_FWD_EN forwards last result into A.
module fpu_cmd_sequencer #(
  parameter int WIDTH   = 16,
  parameter int OP_W    = 4,
  parameter int CC_W    = 4,
  parameter int SF_W    = 5,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmdValid,
  output logic             cmdReady,
  input  logic [OP_W-1:0]  cmdOp,
  input  logic [WIDTH-1:0] cmdA,
  input  logic [WIDTH-1:0] cmdB,
  input  logic [WIDTH-1:0] cmdC,
  input  logic [TAG_W-1:0] cmdTag,
  input  logic             cmdFwd,
  output logic [WIDTH-1:0] fpuIn1,
  output logic [WIDTH-1:0] fpuIn2,
  output logic [WIDTH-1:0] fpuIn3,
  output logic [OP_W-1:0]  fpuOp,
  output logic             fpuStart,
  input  logic [WIDTH-1:0] fpuResult,
  input  logic             fpuDone,
  input  logic [CC_W-1:0]  fpuCC,
  input  logic [SF_W-1:0]  fpuSF,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [WIDTH-1:0] rspData,
  output logic [CC_W-1:0]  rspCC,
  output logic [SF_W-1:0]  rspSF,
  output logic [TAG_W-1:0] rspTag,
  output logic             rspTimeout,
  output logic [SF_W-1:0]  stickyFlags,
  input  logic             flagsClr,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [SF_W-1:0] SF_NV = {1'b1, {(SF_W-1){1'b0}}};

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [TAG_W-1:0] tag;
`ifdef FPU_SEQ_FWD_EN
    logic             fwd;
`endif
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  cmd_t            mem [DEPTH];
  cmd_t            cmdIn;
  cmd_t            head;
  logic [AW:0]     wrPtr;
  logic [AW:0]     rdPtr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [TW-1:0]   timer;
  logic [TAG_W-1:0] tagQ;

`ifdef FPU_SEQ_FWD_EN
  logic [WIDTH-1:0] lastResult;
`else
  logic            unusedFwd;
  assign unusedFwd = cmdFwd;
`endif

  assign empty    = wrPtr == rdPtr;
  assign full     = (wrPtr[AW] != rdPtr[AW]) &&
                    (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign cmdReady = !full && !reset;
  assign push     = cmdValid && cmdReady;
  assign pop      = !empty &&
                    (state == IDLE || (state == RESP && rspReady));
  assign busy     = !empty || state != IDLE;
  assign head     = mem[rdPtr[AW-1:0]];

  // pack the incoming command for storage
  always_comb begin
    cmdIn     = '0;
    cmdIn.op  = cmdOp;
    cmdIn.a   = cmdA;
    cmdIn.b   = cmdB;
    cmdIn.c   = cmdC;
    cmdIn.tag = cmdTag;
`ifdef FPU_SEQ_FWD_EN
    cmdIn.fwd = cmdFwd;
`endif
  end

  // FIFO storage, written on accepted commands
  always_ff @(posedge clock) begin
    if (push) mem[wrPtr[AW-1:0]] <= cmdIn;
  end

  // FIFO pointers with an extra wrap bit for full/empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // issue/wait/respond sequencer with timeout and sticky flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      tagQ        <= '0;
      fpuStart    <= 1'b0;
      fpuIn1      <= '0;
      fpuIn2      <= '0;
      fpuIn3      <= '0;
      fpuOp       <= '0;
      rspValid    <= 1'b0;
      rspData     <= '0;
      rspCC       <= '0;
      rspSF       <= '0;
      rspTag      <= '0;
      rspTimeout  <= 1'b0;
      stickyFlags <= '0;
`ifdef FPU_SEQ_FWD_EN
      lastResult  <= '0;
`endif
    end else begin
      fpuStart <= 1'b0;
      if (flagsClr) stickyFlags <= '0;
      unique case (state)
        IDLE: ;
        ISSUE: begin
          state <= WAIT;
          timer <= TW'(1);
        end
        WAIT: begin
          if (fpuDone) begin
            rspValid    <= 1'b1;
            rspData     <= fpuResult;
            rspCC       <= fpuCC;
            rspSF       <= fpuSF;
            rspTag      <= tagQ;
            rspTimeout  <= 1'b0;
            stickyFlags <= (flagsClr ? '0 : stickyFlags) | fpuSF;
`ifdef FPU_SEQ_FWD_EN
            lastResult  <= fpuResult;
`endif
            state       <= RESP;
          end else if (timer == TMAX) begin
            rspValid    <= 1'b1;
            rspData     <= '1;
            rspCC       <= '0;
            rspSF       <= SF_NV;
            rspTag      <= tagQ;
            rspTimeout  <= 1'b1;
            stickyFlags <= (flagsClr ? '0 : stickyFlags) | SF_NV;
            state       <= RESP;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: begin
          if (rspReady) begin
            rspValid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (pop) begin
`ifdef FPU_SEQ_FWD_EN
        fpuIn1 <= head.fwd ? lastResult : head.a;
`else
        fpuIn1 <= head.a;
`endif
        fpuIn2   <= head.b;
        fpuIn3   <= head.c;
        fpuOp    <= head.op;
        tagQ     <= head.tag;
        fpuStart <= 1'b1;
        state    <= ISSUE;
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer: directed bench with a stub FPU
// (ADD/DIV lookup, optional hang) driving the sequencer.
module tb_fpu_cmd_sequencer;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_DIV = 4'd3;

  logic        clock;
  logic        reset;
  logic        cmdValid;
  logic        cmdReady;
  logic [3:0]  cmdOp;
  logic [15:0] cmdA;
  logic [15:0] cmdB;
  logic [15:0] cmdC;
  logic [3:0]  cmdTag;
  logic        cmdFwd;
  logic [15:0] fpuIn1;
  logic [15:0] fpuIn2;
  logic [15:0] fpuIn3;
  logic [3:0]  fpuOp;
  logic        fpuStart;
  logic [15:0] fpuResult;
  logic        fpuDone;
  logic [3:0]  fpuCC;
  logic [4:0]  fpuSF;
  logic        rspValid;
  logic        rspReady;
  logic [15:0] rspData;
  logic [3:0]  rspCC;
  logic [4:0]  rspSF;
  logic [3:0]  rspTag;
  logic        rspTimeout;
  logic [4:0]  stickyFlags;
  logic        flagsClr;
  logic        busy;
  logic        hang;

  int checks = 0;
  int errors = 0;

  fpu_cmd_sequencer #(
    .WIDTH(16), .OP_W(4), .CC_W(4), .SF_W(5),
    .TAG_W(4), .DEPTH(4), .TIMEOUT(64)
  ) dut (
    .clock(clock), .reset(reset),
    .cmdValid(cmdValid), .cmdReady(cmdReady),
    .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB), .cmdC(cmdC),
    .cmdTag(cmdTag), .cmdFwd(cmdFwd),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .fpuIn3(fpuIn3),
    .fpuOp(fpuOp), .fpuStart(fpuStart),
    .fpuResult(fpuResult), .fpuDone(fpuDone),
    .fpuCC(fpuCC), .fpuSF(fpuSF),
    .rspValid(rspValid), .rspReady(rspReady),
    .rspData(rspData), .rspCC(rspCC), .rspSF(rspSF),
    .rspTag(rspTag), .rspTimeout(rspTimeout),
    .stickyFlags(stickyFlags), .flagsClr(flagsClr),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // stub FPU: {sf, result} for the few operand pairs used here
  function automatic logic [20:0] stubOp(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    if (op == OP_DIV)
      return (b == 16'h0) ? {5'b01000, 16'h7C00} : {5'b0, 16'h3C00};
    if (b == 16'h0001) return {5'b00001, a};
    if (a == 16'h0) return {5'b0, b};
    if (b == 16'h0) return {5'b0, a};
    if (a == b) return {5'b0, a + 16'h0400};
    if ((a == 16'h3C00 && b == 16'h4000) || (a == 16'h4000 && b == 16'h3C00))
      return {5'b0, 16'h4200};
    return {5'b0, 16'h7E00};
  endfunction

  // stub FPU answers one cycle after start unless hung
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fpuDone   <= 1'b0;
      fpuResult <= '0;
      fpuSF     <= '0;
      fpuCC     <= '0;
    end else begin
      fpuDone <= fpuStart && !hang;
      if (fpuStart) begin
        {fpuSF, fpuResult} <= stubOp(fpuOp, fpuIn1, fpuIn2);
        fpuCC <= 4'b0010;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // drive at a negedge, accepted at the next posedge
  task automatic push(input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] tag,
                      input logic fwd);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdA     = a;
    cmdB     = b;
    cmdC     = 16'h0;
    cmdTag   = tag;
    cmdFwd   = fwd;
    @(negedge clock);
    cmdValid = 1'b0;
  endtask

  task automatic waitRsp();
    int n = 0;
    while (!rspValid && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk("rspWait", 32'(rspValid), 32'd1);
  endtask

  task automatic ack();
    rspReady = 1'b1;
    @(negedge clock);
    rspReady = 1'b0;
  endtask

  logic [15:0] ta [5] = '{16'h0000, 16'h3C00, 16'h3C00, 16'h4000, 16'h4000};
  logic [15:0] tb [5] = '{16'h3C00, 16'h3C00, 16'h4000, 16'h4000, 16'h0000};
  logic [15:0] te [5] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4000};

  initial begin
    int got;
    int n;
    reset    = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = '0;
    cmdA     = '0;
    cmdB     = '0;
    cmdC     = '0;
    cmdTag   = '0;
    cmdFwd   = 1'b0;
    rspReady = 1'b0;
    flagsClr = 1'b0;
    hang     = 1'b0;

    // reset held
    repeat (3) @(negedge clock);
    chk("rstCmdReady", 32'(cmdReady), 32'd0);
    chk("rstRspValid", 32'(rspValid), 32'd0);
    chk("rstBusy", 32'(busy), 32'd0);
    chk("rstSticky", 32'(stickyFlags), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("postRstReady", 32'(cmdReady), 32'd1);

    // basic ADD
    push(OP_ADD, 16'h3C00, 16'h4000, 4'd3, 1'b0);
    chk("t1StartLow", 32'(fpuStart), 32'd0);
    chk("t1Busy", 32'(busy), 32'd1);
    @(negedge clock);
    chk("t1Start", 32'(fpuStart), 32'd1);
    chk("t1In1", 32'(fpuIn1), 32'h3C00);
    chk("t1In2", 32'(fpuIn2), 32'h4000);
    @(negedge clock);
    chk("t1StartPulse", 32'(fpuStart), 32'd0);
    chk("t1RspEarly", 32'(rspValid), 32'd0);
    @(negedge clock);
    chk("t1RspValid", 32'(rspValid), 32'd1);
    chk("t1Data", 32'(rspData), 32'h4200);
    chk("t1Tag", 32'(rspTag), 32'd3);
    chk("t1Timeout", 32'(rspTimeout), 32'd0);
    chk("t1CC", 32'(rspCC), 32'h2);
    chk("t1Sticky", 32'(stickyFlags), 32'd0);
    ack();
    chk("t1RspDone", 32'(rspValid), 32'd0);
    chk("t1Idle", 32'(busy), 32'd0);

    // back-pressure fills the FIFO
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("t2ReadyBefore5", 32'(cmdReady), 32'd1);
      cmdValid = 1'b1;
      cmdOp    = OP_ADD;
      cmdA     = ta[i];
      cmdB     = tb[i];
      cmdTag   = 4'(i + 1);
      @(negedge clock);
    end
    cmdValid = 1'b0;
    chk("t2Full", 32'(cmdReady), 32'd0);
    chk("t2HeadRsp", 32'(rspValid), 32'd1);
    chk("t2HeadTag", 32'(rspTag), 32'd1);
    rspReady = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 100) begin
      if (rspValid) begin
        chk("t2Tag", 32'(rspTag), 32'(got + 1));
        chk("t2Data", 32'(rspData), 32'(te[got]));
        got++;
      end
      @(negedge clock);
      n++;
    end
    rspReady = 1'b0;
    chk("t2Count", 32'(got), 32'd5);
    chk("t2Ready", 32'(cmdReady), 32'd1);

    // divide by zero, then clear coinciding with NX completion
    push(OP_DIV, 16'h3C00, 16'h0000, 4'd4, 1'b0);
    waitRsp();
    chk("t3DivData", 32'(rspData), 32'h7C00);
    chk("t3DivSF", 32'(rspSF), 32'b01000);
    chk("t3DivSticky", 32'(stickyFlags), 32'b01000);
    ack();
    push(OP_ADD, 16'h3C00, 16'h0001, 4'd5, 1'b0);
    @(negedge clock);
    chk("t3Start", 32'(fpuStart), 32'd1);
    @(negedge clock);
    chk("t3StickyHeld", 32'(stickyFlags), 32'b01000);
    flagsClr = 1'b1;
    @(negedge clock);
    flagsClr = 1'b0;
    chk("t3NxRsp", 32'(rspValid), 32'd1);
    chk("t3NxSF", 32'(rspSF), 32'b00001);
    chk("t3ClrSticky", 32'(stickyFlags), 32'b00001);
    ack();

    // watchdog timeout, then a queued command runs normally
    hang = 1'b1;
    push(OP_ADD, 16'h3C00, 16'h4000, 4'd7, 1'b0);
    push(OP_ADD, 16'h4000, 16'h4000, 4'd8, 1'b0);
    chk("t4Start", 32'(fpuStart), 32'd1);
    n = 0;
    while (!rspValid && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t4Latency", 32'(n), 32'd65);
    chk("t4Timeout", 32'(rspTimeout), 32'd1);
    chk("t4Data", 32'(rspData), 32'hFFFF);
    chk("t4SF", 32'(rspSF), 32'b10000);
    chk("t4CC", 32'(rspCC), 32'd0);
    chk("t4Tag", 32'(rspTag), 32'd7);
    chk("t4Sticky", 32'(stickyFlags), 32'b10001);
    hang = 1'b0;
    ack();
    waitRsp();
    chk("t4NextTag", 32'(rspTag), 32'd8);
    chk("t4NextTimeout", 32'(rspTimeout), 32'd0);
    chk("t4NextData", 32'(rspData), 32'h4400);
    ack();

    // async reset in the middle of WAIT
    hang = 1'b1;
    push(OP_ADD, 16'h3C00, 16'h3C00, 4'd9, 1'b0);
    @(negedge clock);
    chk("t5Start", 32'(fpuStart), 32'd1);
    @(negedge clock);
    chk("t5Busy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("t5Busy0", 32'(busy), 32'd0);
    chk("t5In1", 32'(fpuIn1), 32'd0);
    chk("t5Sticky", 32'(stickyFlags), 32'd0);
    chk("t5RspValid", 32'(rspValid), 32'd0);
    chk("t5Ready", 32'(cmdReady), 32'd0);
    hang = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t5ReadyAfter", 32'(cmdReady), 32'd1);
    chk("t5Empty", 32'(busy), 32'd0);

    // forwarding chain
    push(OP_ADD, 16'h3C00, 16'h3C00, 4'd1, 1'b0);
    waitRsp();
    chk("t6First", 32'(rspData), 32'h4000);
    ack();
    push(OP_ADD, 16'h0000, 16'h3C00, 4'd2, 1'b1);
    @(negedge clock);
    chk("t6Start", 32'(fpuStart), 32'd1);
`ifdef FPU_SEQ_FWD_EN
    chk("t6In1", 32'(fpuIn1), 32'h4000);
`else
    chk("t6In1", 32'(fpuIn1), 32'h0000);
`endif
    waitRsp();
`ifdef FPU_SEQ_FWD_EN
    chk("t6Data", 32'(rspData), 32'h4200);
`else
    chk("t6Data", 32'(rspData), 32'h3C00);
`endif
    ack();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
